// File: rtl/transmit_engine.sv
// UART transmitter: frames one byte (start, 7/8 data, optional parity, stop)
// and shifts it out LSB-first at a baud rate chosen from a fixed 100 MHz table.
module transmit_engine (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] out_port,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic [3:0] BAUD,
  output logic       Tx,
  output logic       TxRDY
);

  // state | meaning
  // IDLE  | line high, TxRDY=1, waiting for load
  // SEND  | shifting the 10 bit-time frame out on Tx
  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q,    state_d;
  logic [18:0] baud_cnt_q, baud_cnt_d;
  logic [18:0] div_q,      div_d;
  logic [3:0]  bit_cnt_q,  bit_cnt_d;
  logic [8:0]  shift_q,    shift_d;
  logic        tx_q,       tx_d;
  logic        txrdy_q,    txrdy_d;

  logic        bit9, bit10;
  logic        p7, p8;

  // Returns clocks-per-bit minus one so the counter compares directly.
  function automatic logic [18:0] div_lookup(input logic [3:0] sel);
    case (sel)
      4'h0:    div_lookup = 19'd333332;
      4'h1:    div_lookup = 19'd166666;
      4'h2:    div_lookup = 19'd83332;
      4'h3:    div_lookup = 19'd41666;
      4'h4:    div_lookup = 19'd20832;
      4'h5:    div_lookup = 19'd10416;
      4'h6:    div_lookup = 19'd5207;
      4'h7:    div_lookup = 19'd2603;
      4'h8:    div_lookup = 19'd1735;
      4'h9:    div_lookup = 19'd867;
      4'hA:    div_lookup = 19'd433;
      4'hB:    div_lookup = 19'd216;
      default: div_lookup = 19'd108;
    endcase
  endfunction

  always_comb begin
    p7 = (^out_port[6:0]) ^ OHEL;
    p8 = (^out_port[7:0]) ^ OHEL;
    case ({EIGHT, PEN})
      2'b00:   begin bit9 = 1'b1;        bit10 = 1'b1; end
      2'b01:   begin bit9 = p7;          bit10 = 1'b1; end
      2'b10:   begin bit9 = out_port[7]; bit10 = 1'b1; end
      default: begin bit9 = out_port[7]; bit10 = p8;   end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    txrdy_d    = txrdy_q;

    case (state_q)
      IDLE: begin
        if (load && txrdy_q) begin
          state_d    = SEND;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          div_d      = div_lookup(BAUD);
          // Start bit goes out now; the shifter holds the remaining nine bits.
          shift_d    = {bit10, bit9, out_port[6:0]};
          tx_d       = 1'b0;
          txrdy_d    = 1'b0;
        end
      end
      SEND: begin
        if (baud_cnt_q == div_q) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 4'd9) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            txrdy_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b1, shift_q[8:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 19'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '1;
      tx_q       <= 1'b1;
      txrdy_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      txrdy_q    <= txrdy_d;
    end
  end

  assign Tx    = tx_q;
  assign TxRDY = txrdy_q;

endmodule

// File: tb/tb_transmit_engine.sv
// Directed bench for transmit_engine: frame contents, bit timing, handshake,
// back-to-back frames, mid-frame config changes and reset abort.
module tb_transmit_engine;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] out_port;
  logic       EIGHT, PEN, OHEL;
  logic [3:0] BAUD;
  logic       Tx, TxRDY;

  int n_vec = 0;
  int n_err = 0;

  // Frame bits i=0..9 as {bit10, bit9, d6..d0, start} with start on bit 0.
  localparam logic [7:0] A5_LOW = 8'b0100_1010;
  localparam logic [7:0] C3_LOW = 8'b0111_1000;

  transmit_engine dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .out_port (out_port),
    .EIGHT    (EIGHT),
    .PEN      (PEN),
    .OHEL     (OHEL),
    .BAUD     (BAUD),
    .Tx       (Tx),
    .TxRDY    (TxRDY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Called at the sample point just after the accept edge (cycle 0).
  task automatic frame_check(input string tag, input logic [9:0] bits,
                             input int n, input bit toggle);
    logic obs_bit;
    logic rdy_seen;
    rdy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      obs_bit = bits[i];
      for (int c = 0; c < n; c++) begin
        if (Tx !== bits[i]) obs_bit = Tx;
        if (TxRDY !== 1'b0) rdy_seen = 1'b1;
        if (toggle) load = ~load;
        @(posedge clk); #1;
      end
      chk($sformatf("%s_bit%0d", tag, i), {31'd0, obs_bit}, {31'd0, bits[i]});
    end
    chk({tag, "_rdy_busy"}, {31'd0, rdy_seen}, 32'd0);
    chk({tag, "_end_tx"},   {31'd0, Tx},       32'd1);
    chk({tag, "_end_rdy"},  {31'd0, TxRDY},    32'd1);
  endtask

  logic [2:0] mode_tab [5] = '{3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
  logic [1:0] b10b9_tab [5] = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11};

  initial begin
    logic idle_bad;
    rst = 1'b1; load = 1'b0; out_port = 8'hA5;
    EIGHT = 1'b0; PEN = 1'b0; OHEL = 1'b0; BAUD = 4'hB;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",  {31'd0, Tx},    32'd1);
    chk("rst_rdy", {31'd0, TxRDY}, 32'd1);
    rst = 1'b0;

    idle_bad = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Tx !== 1'b1 || TxRDY !== 1'b1) idle_bad = 1'b1;
    end
    chk("idle_quiet", {31'd0, idle_bad}, 32'd0);

    pulse_load();
    frame_check("m000", {2'b11, A5_LOW}, 217, 1'b0);

    for (int m = 0; m < 5; m++) begin
      {EIGHT, PEN, OHEL} = mode_tab[m];
      @(posedge clk); #1;
      pulse_load();
      frame_check($sformatf("m%03b", mode_tab[m]), {b10b9_tab[m], A5_LOW}, 217, 1'b0);
    end

    // Held load: each new frame must start on the edge right after TxRDY rises.
    {EIGHT, PEN, OHEL} = 3'b111;
    load = 1'b1;
    for (int f = 0; f < 3; f++) begin
      @(posedge clk); #1;
      frame_check($sformatf("held%0d", f), {2'b11, A5_LOW}, 217, (f == 1));
      load = (f < 2);
    end
    @(posedge clk); #1;

    pulse_load();
    out_port = 8'h3C;
    BAUD     = 4'hC;
    frame_check("chg_old", {2'b11, A5_LOW}, 217, 1'b0);
    pulse_load();
    frame_check("chg_new", {2'b10, C3_LOW}, 109, 1'b0);

    out_port = 8'hA5;
    @(posedge clk); #1;
    pulse_load();
    repeat (300) begin @(posedge clk); #1; end
    rst = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    chk("abort_tx",  {31'd0, Tx},    32'd1);
    chk("abort_rdy", {31'd0, TxRDY}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    load = 1'b0;
    frame_check("post_rst", {2'b11, A5_LOW}, 109, 1'b0);

    rst = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; load = 1'b0;
    chk("rst_load_tx",  {31'd0, Tx},    32'd1);
    chk("rst_load_rdy", {31'd0, TxRDY}, 32'd1);
    @(posedge clk); #1;
    chk("rst_load_ign", {31'd0, TxRDY}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
